// File: rtl/ser3_deframer.sv
// ser3_deframer: framed serial input to three registered data lanes.
// Frame in sample order: start (0), D0, D1, D2, then STOP_BITS ones.
// Only edges with in_EN high advance the receiver. A bad stop bit raises
// out_FERR, and the line must then return high before a new start bit counts.

module ser3_deframer #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic in_CLK,
  input  logic in_RST,
  input  logic in_SER,
  input  logic in_EN,
  output logic out_A,
  output logic out_B,
  output logic out_C,
  output logic out_ALL,
  output logic out_VALID,
  output logic out_FERR,
  output logic out_BUSY
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StData  = 2'd1;
  localparam logic [1:0] StStop  = 2'd2;
  localparam logic [1:0] StBreak = 2'd3;

  // Counter value that marks the final stop sample.
  localparam logic [1:0] LastStop = 2'(STOP_BITS - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] hold_q, hold_d;
  logic [2:0] lanes_q, lanes_d;
  logic       all_q, all_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       busy_q, busy_d;

  // Next-state logic; an unstrobed edge leaves everything unchanged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    lanes_d = lanes_q;
    all_d   = all_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (in_EN) begin
      unique case (state_q)
        StIdle: begin
          if (!in_SER) begin
            state_d = StData;
            cnt_d   = 2'd0;
            hold_d  = 3'b000;
          end
        end

        StData: begin
          // Bit counter selects the holding-register slot for this sample.
          case (cnt_q)
            2'd0:    hold_d[0] = in_SER;
            2'd1:    hold_d[1] = in_SER;
            default: hold_d[2] = in_SER;
          endcase
          if (cnt_q == 2'd2) begin
            state_d = StStop;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end

        StStop: begin
          if (in_SER) begin
            if (cnt_q == LastStop) begin
              lanes_d = hold_q;
              all_d   = &hold_q;
              valid_d = 1'b1;
              state_d = StIdle;
              cnt_d   = 2'd0;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end else begin
            // The lanes keep their last good frame.
            ferr_d  = 1'b1;
            state_d = StBreak;
            cnt_d   = 2'd0;
          end
        end

        StBreak: begin
          // A held-low line must go high before a new start bit is accepted.
          if (in_SER) begin
            state_d = StIdle;
          end
        end

        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      hold_q  <= 3'b000;
      lanes_q <= 3'b000;
      all_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      lanes_q <= lanes_d;
      all_q   <= all_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign out_A     = lanes_q[0];
  assign out_B     = lanes_q[1];
  assign out_C     = lanes_q[2];
  assign out_ALL   = all_q;
  assign out_VALID = valid_q;
  assign out_FERR  = ferr_q;
  assign out_BUSY  = busy_q;

endmodule

// File: tb/tb_ser3_deframer.sv
// Bench for ser3_deframer: two instances (STOP_BITS 1 and 2) share one stream.
// A frame-level model predicts events into per-instance queues; a monitor pops
// and compares when the DUT shows VALID or FERR, and checks lanes and BUSY.

module tb_ser3_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, ser;
  logic a1, b1, c1, all1, v1, f1, bz1;
  logic a2, b2, c2, all2, v2, f2, bz2;

  ser3_deframer #(.STOP_BITS(1)) u_sb1 (
    .in_CLK(clk), .in_RST(rst), .in_SER(ser), .in_EN(en),
    .out_A(a1), .out_B(b1), .out_C(c1), .out_ALL(all1),
    .out_VALID(v1), .out_FERR(f1), .out_BUSY(bz1)
  );

  ser3_deframer #(.STOP_BITS(2)) u_sb2 (
    .in_CLK(clk), .in_RST(rst), .in_SER(ser), .in_EN(en),
    .out_A(a2), .out_B(b2), .out_C(c2), .out_ALL(all2),
    .out_VALID(v2), .out_FERR(f2), .out_BUSY(bz2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    int       stamp;
    bit       ferr;
    logic [2:0] lanes;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  // Model: samples taken in the current frame, collected data, break flag.
  int         mlen[2];
  logic [2:0] mdata[2];
  bit         mbrk[2];
  logic [2:0] mlanes[2];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  task automatic push_ev(int i, bit is_ferr, logic [2:0] l);
    ev_t e;
    e.stamp = cyc;
    e.ferr  = is_ferr;
    e.lanes = l;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // One strobed sample applied to the frame-level model of instance i.
  task automatic model_step(int i, bit s);
    int sb;
    sb = i + 1;
    if (mbrk[i]) begin
      if (s) mbrk[i] = 1'b0;
    end else if (mlen[i] == 0) begin
      if (!s) mlen[i] = 1;
    end else if (mlen[i] < 4) begin
      mdata[i][mlen[i]-1] = s;
      mlen[i]++;
    end else if (!s) begin
      push_ev(i, 1'b1, mlanes[i]);
      mlen[i] = 0;
      mbrk[i] = 1'b1;
    end else if (mlen[i] == 3 + sb) begin
      mlanes[i] = mdata[i];
      push_ev(i, 1'b0, mdata[i]);
      mlen[i] = 0;
    end else begin
      mlen[i]++;
    end
  endtask

  // Model advances on the same edges the DUT samples.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mlen[i]   = 0;
        mbrk[i]   = 1'b0;
        mlanes[i] = 3'b000;
        mdata[i]  = 3'b000;
      end else if (en) begin
        model_step(i, ser);
      end
    end
  end

  task automatic check_inst(int i, logic [2:0] lanes, logic all, logic v, logic f, logic bz);
    ev_t e;
    bit have;
    string p;
    p = (i == 0) ? "sb1" : "sb2";
    chk({p, "_lanes"}, 32'(lanes), 32'(mlanes[i]));
    chk({p, "_all"}, 32'(all), 32'(&mlanes[i]));
    chk({p, "_busy"}, 32'(bz), 32'(mbrk[i] || mlen[i] != 0));
    chk({p, "_vld_ferr_excl"}, 32'(v & f), 32'(0));
    have = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].stamp <= cyc) begin
        e = q0.pop_front();
        have = 1'b1;
      end
    end else begin
      if (q1.size() > 0 && q1[0].stamp <= cyc) begin
        e = q1.pop_front();
        have = 1'b1;
      end
    end
    if (have) begin
      chk({p, "_ev_cycle"}, 32'(e.stamp), 32'(cyc));
      chk({p, "_valid"}, 32'(v), 32'(!e.ferr));
      chk({p, "_ferr"}, 32'(f), 32'(e.ferr));
      chk({p, "_ev_lanes"}, 32'(lanes), 32'(e.lanes));
    end else begin
      chk({p, "_no_valid"}, 32'(v), 32'(0));
      chk({p, "_no_ferr"}, 32'(f), 32'(0));
    end
  endtask

  // Monitor on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      check_inst(0, {c1, b1, a1}, all1, v1, f1, bz1);
      check_inst(1, {c2, b2, a2}, all2, v2, f2, bz2);
    end
  end

  task automatic step(bit r, bit e, bit s);
    rst = r;
    en  = e;
    ser = s;
    @(posedge clk);
    #1;
  endtask

  // Strobed samples from a string of '0'/'1'; optional idle gaps before each.
  task automatic seq(string s, bit gaps);
    for (int k = 0; k < s.len(); k++) begin
      if (gaps) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b1, s[k] == 8'h31);
    end
  endtask

  task automatic emit(bit s);
    if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1, s);
  endtask

  initial begin
    // Reset with the line low.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    mon_on = 1'b1;
    chk("rst_outs_sb1", 32'({a1, b1, c1, all1, v1, f1, bz1}), 32'(0));
    chk("rst_outs_sb2", 32'({a2, b2, c2, all2, v2, f2, bz2}), 32'(0));
    seq("11", 1'b0);

    // Single good frame.
    seq("01011", 1'b0);
    chk("single_lanes", 32'({c1, b1, a1}), 32'(3'b101));
    chk("single_all", 32'(all1), 32'(0));
    chk("single_valid", 32'(v1), 32'(1));
    chk("single_busy", 32'(bz1), 32'(0));
    seq("111", 1'b0);

    // All-ones frame, then back-to-back frame.
    seq("01111", 1'b0);
    chk("ones_all", 32'(all1), 32'(1));
    seq("00011", 1'b0);
    chk("b2b_lanes", 32'({c1, b1, a1}), 32'(3'b100));
    chk("b2b_valid", 32'(v1), 32'(1));
    seq("111", 1'b0);

    // Framing error and break recovery.
    seq("01110", 1'b0);
    chk("ferr_pulse", 32'(f1), 32'(1));
    seq("00", 1'b0);
    chk("break_busy", 32'(bz1), 32'(1));
    seq("1", 1'b0);
    chk("break_idle", 32'(bz1), 32'(0));
    seq("11", 1'b0);

    // Strobe gaps with two stop bits.
    seq("001111", 1'b1);
    chk("sb2_valid", 32'(v2), 32'(1));
    chk("sb2_lanes", 32'({c2, b2, a2}), 32'(3'b110));
    seq("11", 1'b0);
    seq("001110", 1'b1);
    chk("sb2_ferr", 32'(f2), 32'(1));
    seq("11", 1'b0);

    // Reset mid-frame, then a complete frame.
    step(1'b1, 1'b1, 1'b0);
    seq("11", 1'b0);
    seq("001", 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("midrst_lanes", 32'({c1, b1, a1}), 32'(0));
    seq("01101", 1'b0);
    chk("after_rst_lanes", 32'({c1, b1, a1}), 32'(3'b011));
    seq("111", 1'b0);

    // Randomized frames with gaps, bad stops, noise and occasional reset.
    repeat (300) begin
      repeat ($urandom_range(0, 2)) emit(1'b1);
      emit(1'b0);
      repeat (3) emit(1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 2)) emit($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0)
        repeat ($urandom_range(1, 4)) emit(1'($urandom_range(0, 1)));
    end

    seq("1111", 1'b0);
    @(negedge clk);
    #1;
    chk("q_sb1_drained", 32'(q0.size()), 32'(0));
    chk("q_sb2_drained", 32'(q1.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser3_deframer.md
# ser3_deframer

Serial-to-3-lane deframer: receives a framed serial bitstream and distributes its three data bits onto parallel lanes `out_A`/`out_B`/`out_C`. It is the driving end for the team's 3-input gate blocks: one wire in, three registered lines out. It also produces a registered all-ones flag, equal to the AND of the three lanes, as a convenience.

## Interface
- `STOP_BITS`, default 1: number of stop samples required per frame. Legal values are 1 and 2.
- `in_CLK`  input  1  clock. All logic is on the rising edge.
- `in_RST`  input  1  reset. Synchronous and active-high.
- `in_SER`  input  1  serial line. Idle level is 1.
- `in_EN`  input  1  bit strobe. `in_SER` is sampled only on edges where `in_EN` = 1.
- `out_A`  output  1  data bit 0, the first bit after the start bit. Registered.
- `out_B`  output  1  data bit 1. Registered.
- `out_C`  output  1  data bit 2. Registered.
- `out_ALL`  output  1  `out_A & out_B & out_C`. Registered and updated together with the lanes.
- `out_VALID`  output  1  one-cycle pulse when a good frame has been latched.
- `out_FERR`  output  1  one-cycle pulse on a framing error.
- `out_BUSY`  output  1  high while a frame is in progress or a break is pending.

## Operation
- Frame format, in sample order: start bit (0), D0, D1, D2, then `STOP_BITS` × 1.
- States: IDLE, DATA, STOP, BREAK. A 2-bit bit counter indexes the data and stop bits.
- In every state, an edge with `in_EN` = 0 changes nothing: state, counter and shift register all hold.
- **IDLE:**
  - A sample of 0 is the start bit → DATA, counter = 0.
  - A sample of 1 → stay in IDLE.
- **DATA:**
  - Each sample is shifted into a 3-bit holding register at position `counter`.
  - After the sample at counter = 2 → STOP, counter = 0.
- **STOP:**
  - Sample 1 and it is the final stop bit → latch the holding register to `out_A`/`out_B`/`out_C`, set `out_ALL`, pulse `out_VALID`, → IDLE.
  - Sample 1 with a further stop bit still due (`STOP_BITS` = 2) → increment counter, stay in STOP.
  - Sample 0 → pulse `out_FERR`, → BREAK. The lanes and `out_ALL` keep their previous values.
- **BREAK:**
  - Wait for a sample of 1, then → IDLE. A continuing low line is never taken as a new start bit.
- The lanes and `out_ALL` change only on a valid frame. They hold their values between frames.
- `out_BUSY` = 1 in DATA, STOP and BREAK; 0 in IDLE.
- `out_VALID` and `out_FERR` are never high in the same cycle.

## Timing
- All outputs are registered. Every output resets to 0, and the state resets to IDLE.
- Latency: the lanes and `out_VALID` are updated on the same edge that samples the final stop bit. They are visible in the following cycle, for exactly one cycle in the case of `out_VALID`.
- Minimum frame length is 4 + `STOP_BITS` strobed samples. Back-to-back frames are supported: a start bit may be sampled on the strobe immediately after the final stop bit.
- Reset mid-frame, or asserted together with `in_EN`: the frame is abandoned, no `out_VALID` or `out_FERR` is produced, and the block is in IDLE the next cycle. Reset has priority over any sample.
- `in_EN` is tied to 1: one bit is sampled per clock.
- `in_EN` has gaps: the result is identical to the contiguous case, and only the number of strobed edges matters.

## Test plan
- **Reset values.** Assert `in_RST` for 2 cycles with `in_SER` = 0 → all outputs are 0 and the block is in IDLE. The first sample of 0 after reset is treated as a start bit.
- **Single good frame.** `STOP_BITS` = 1, `in_EN` = 1, drive 0,1,0,1,1 → one cycle after the 5th edge: A=1, B=0, C=1, ALL=0, VALID pulses for 1 cycle, BUSY=0.
- **All-ones frame, then back-to-back frame.** Drive 0,1,1,1,1 then 0,0,0,1,1 → first frame gives ALL=1 with VALID. Second frame gives A=B=0, C=1, ALL=0, with a second VALID exactly 5 cycles later.
- **Framing error and break recovery.** Drive 0,1,1,1,0,0,0,1 → FERR pulses once after the 5th sample. The lanes keep their prior values, and BUSY stays high through the low run. The trailing 1 returns the block to IDLE with no VALID.
- **Strobe gaps and STOP_BITS = 2.** Drive 0,0,1,1,1,1 with `in_EN` low on alternate cycles → VALID appears only after the 6th strobed sample, with A=0, B=1, C=1. A 0 on the second stop sample instead yields FERR.
- **Reset mid-frame.** Assert `in_RST` after D1 has been sampled → no VALID or FERR, and the lanes are 0. A following complete frame 0,1,1,0,1 gives A=1, B=1, C=0.
